// File: rtl/bcd_serial_deserializer_if.sv
// rtl/bcd_serial_deserializer_if.sv - serial BCD input and assembled digit outputs
interface bcd_serial_deserializer_if;
  logic       sin_valid;
  logic       sin;
  logic       sof;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       dout_valid;
  logic       dout_err;
  logic       timeout;
  logic       busy;
  logic [7:0] digit_cnt;

  modport master (
    output sin_valid, sin, sof,
    input  a, b, c, d, dout_valid, dout_err, timeout, busy, digit_cnt
  );

  modport slave (
    input  sin_valid, sin, sof,
    output a, b, c, d, dout_valid, dout_err, timeout, busy, digit_cnt
  );
endinterface

// File: rtl/bcd_serial_deserializer.sv
// rtl/bcd_serial_deserializer.sv - assembles serial BCD digits, flags illegal codes and stalls
module bcd_serial_deserializer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 15
) (
  input logic                       clk,
  input logic                       rst,
  bcd_serial_deserializer_if.slave  bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [3:0] nib_q, nib_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dv_q, dv_d;
  logic       err_q, err_d;
  logic       to_q, to_d;
  logic       busy_q, busy_d;
  logic [3:0] base;
  logic [3:0] shifted;
  logic [7:0] idle_inc;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    nib_d      = nib_q;
    cnt_d      = cnt_q;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    to_d       = 1'b0;
    // A start bit always begins from an empty register, so restarts drop the partial digit.
    base       = bus.sof ? 4'd0 : shift_q;
    shifted    = MSB_FIRST ? {base[2:0], bus.sin} : {bus.sin, base[3:1]};
    idle_inc   = idle_cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (bus.sin_valid && bus.sof) begin
          state_d    = SHIFT;
          shift_d    = shifted;
          bit_cnt_d  = 3'd1;
          idle_cnt_d = 8'd0;
        end
      end
      SHIFT: begin
        if (bus.sin_valid) begin
          idle_cnt_d = 8'd0;
          if (bus.sof) begin
            shift_d   = shifted;
            bit_cnt_d = 3'd1;
          end else if (bit_cnt_q == 3'd3) begin
            state_d   = IDLE;
            shift_d   = 4'd0;
            bit_cnt_d = 3'd0;
            if (shifted <= 4'd9) begin
              nib_d = shifted;
              dv_d  = 1'b1;
              cnt_d = cnt_q + 8'd1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          idle_cnt_d = idle_inc;
          if (idle_inc == TIMEOUT_C) begin
            state_d    = IDLE;
            to_d       = 1'b1;
            shift_d    = 4'd0;
            bit_cnt_d  = 3'd0;
            idle_cnt_d = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 4'd0;
      bit_cnt_q  <= 3'd0;
      idle_cnt_q <= 8'd0;
      nib_q      <= 4'd0;
      cnt_q      <= 8'd0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      nib_q      <= nib_d;
      cnt_q      <= cnt_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
      to_q       <= to_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.a          = nib_q[3];
  assign bus.b          = nib_q[2];
  assign bus.c          = nib_q[1];
  assign bus.d          = nib_q[0];
  assign bus.dout_valid = dv_q;
  assign bus.dout_err   = err_q;
  assign bus.timeout    = to_q;
  assign bus.busy       = busy_q;
  assign bus.digit_cnt  = cnt_q;
endmodule

// File: tb/tb_bcd_serial_deserializer.sv
// tb/tb_bcd_serial_deserializer.sv - randomized and directed bench for both bit orders
module tb_bcd_serial_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  bcd_serial_deserializer_if if0 ();
  bcd_serial_deserializer_if if1 ();

  bcd_serial_deserializer #(.MSB_FIRST(1'b1), .TIMEOUT(15)) u_msb (.clk(clk), .rst(rst), .bus(if0));
  bcd_serial_deserializer #(.MSB_FIRST(1'b0), .TIMEOUT(3))  u_lsb (.clk(clk), .rst(rst), .bus(if1));

  // Reference model: frame as a list of received bits, value computed by weighting.
  int       m_in   [2];
  int       m_n    [2];
  int       m_bits [2][4];
  int       m_idle [2];
  int       m_nib  [2];
  int       m_cnt  [2];
  int       m_dv   [2];
  int       m_de   [2];
  int       m_to   [2];

  function automatic int timeout_of(input int i);
    return (i == 0) ? 15 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_in[i] = 0; m_n[i] = 0; m_idle[i] = 0; m_nib[i] = 0;
      m_cnt[i] = 0; m_dv[i] = 0; m_de[i] = 0; m_to[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic sv, input logic sf, input logic s);
    int val;
    m_dv[i] = 0; m_de[i] = 0; m_to[i] = 0;
    if (sv) begin
      if (sf) begin
        m_in[i] = 1; m_bits[i][0] = int'(s); m_n[i] = 1; m_idle[i] = 0;
      end else if (m_in[i] != 0) begin
        m_bits[i][m_n[i]] = int'(s);
        m_n[i]++;
        m_idle[i] = 0;
        if (m_n[i] == 4) begin
          val = 0;
          for (int k = 0; k < 4; k++)
            val += (i == 0) ? m_bits[i][k] * (8 >> k) : m_bits[i][k] * (1 << k);
          if (val < 10) begin
            m_nib[i] = val; m_dv[i] = 1; m_cnt[i] = (m_cnt[i] + 1) % 256;
          end else begin
            m_de[i] = 1;
          end
          m_in[i] = 0;
        end
      end
    end else if (m_in[i] != 0) begin
      m_idle[i]++;
      if (m_idle[i] == timeout_of(i)) begin
        m_to[i] = 1; m_in[i] = 0;
      end
    end
  endtask

  function automatic logic [15:0] expected(input int i);
    return {4'(m_nib[i]), 1'(m_dv[i]), 1'(m_de[i]), 1'(m_to[i]), 1'(m_in[i] != 0), 8'(m_cnt[i])};
  endfunction

  function automatic logic [15:0] observed(input int i);
    if (i == 0)
      return {if0.a, if0.b, if0.c, if0.d, if0.dout_valid, if0.dout_err, if0.timeout, if0.busy, if0.digit_cnt};
    return {if1.a, if1.b, if1.c, if1.d, if1.dout_valid, if1.dout_err, if1.timeout, if1.busy, if1.digit_cnt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "/msb"}, 32'(observed(0)), 32'(expected(0)));
    check({tag, "/lsb"}, 32'(observed(1)), 32'(expected(1)));
  endtask

  task automatic drive(input logic sv, input logic sf, input logic s);
    @(negedge clk);
    if0.sin_valid = sv; if0.sof = sf; if0.sin = s;
    if1.sin_valid = sv; if1.sof = sf; if1.sin = s;
    @(posedge clk);
    model_step(0, sv, sf, s);
    model_step(1, sv, sf, s);
    #1;
    check_both("cycle");
  endtask

  task automatic send(input logic [3:0] fb, input int n);
    for (int k = 0; k < n; k++)
      drive(1'b1, k == 0, fb[3-k]);
  endtask

  initial begin
    int         legal [7] = '{0, 1, 2, 4, 6, 8, 9};
    logic [3:0] v;
    logic [7:0] cnt0_before, cnt1_before;

    if0.sin_valid = 1'b0; if0.sof = 1'b0; if0.sin = 1'b0;
    if1.sin_valid = 1'b0; if1.sof = 1'b0; if1.sin = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_both("reset");
    rst = 1'b0;

    send(4'b0111, 4);
    check("first_digit", 32'(observed(0)), 32'({4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}));
    send(4'b1100, 4);
    check("illegal_12", 32'(observed(0)), 32'({4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1}));

    send(4'b1000, 2);
    repeat (14) drive(1'b0, 1'b0, 1'b0);
    check("pre_timeout_busy", 32'(if0.busy), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    check("timeout_pulse", 32'({if0.timeout, if0.busy, if0.a, if0.b, if0.c, if0.d}), 32'(6'b10_0111));
    send(4'b1001, 4);
    check("after_timeout", 32'({if0.a, if0.b, if0.c, if0.d}), 32'd9);

    send(4'b1100, 2);
    send(4'b0011, 4);
    check("restart", 32'({if0.a, if0.b, if0.c, if0.d, if0.dout_valid}), 32'(5'b0011_1));

    send(4'b1000, 4);
    check("lsb_first", 32'({if1.a, if1.b, if1.c, if1.d}), 32'd1);

    cnt0_before = if0.digit_cnt;
    cnt1_before = if1.digit_cnt;
    for (int n = 0; n < 256; n++) begin
      v = 4'(legal[$urandom_range(6)]);
      send(v, 4);
    end
    check("wrap_msb", 32'(if0.digit_cnt), 32'(cnt0_before));
    check("wrap_lsb", 32'(if1.digit_cnt), 32'(cnt1_before));

    for (int n = 0; n < 3000; n++)
      drive(($urandom_range(3) != 0), ($urandom_range(4) == 0), 1'($urandom));

    send(4'b0101, 3);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_both("async_reset");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    check("stray_bit", 32'(if0.busy), 32'd0);
    send(4'b0101, 4);
    check("post_reset", 32'({if0.a, if0.b, if0.c, if0.d, if0.digit_cnt}), 32'({4'b0101, 8'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
